seg_updown_counter: RTL
=======================

SEG_UPDOWN_COUNTER -- requirements
Module: seg_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits and seven-segment displays, legal range 1-6.
REQ-002 Parameter MAX_VALUE, default 99: upper count bound, decimal, legal range 1 to 10^DIGITS-1.
REQ-003 Parameter PRESCALE, default 1: enabled clk cycles per count step, legal range 1-2^16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  count enable; 1 = counting, 0 = hold.
REQ-007 ud  input  1  direction; 0 = up, 1 = down.
REQ-008 wrap  input  1  boundary mode; 1 = wrap, 0 = saturate.
REQ-009 load  input  1  single-cycle request to load startValue.
REQ-010 startValue  input  4*DIGITS  BCD load value; digit 0 in bits [3:0].
REQ-011 count  output  4*DIGITS  current BCD count, registered.
REQ-012 HEX  output  7*DIGITS  active-low segments; digit i occupies bits [7i+6:7i], ordered {g,f,e,d,c,b,a}.
REQ-013 tc  output  1  terminal-count pulse, registered.
REQ-014 err  output  1  rejected-load pulse, registered.

Function
REQ-015 The count register shall be held directly in BCD; no digit shall ever hold a value above 9.
REQ-016 Priority shall be reset > load > count step.
REQ-017 On load, if every digit is <= 9 and the value is <= MAX_VALUE, count shall take startValue on the next edge, the prescaler shall clear, and err shall be 0.
REQ-018 On an invalid load, count shall be unchanged and err shall be 1 for exactly one cycle.
REQ-019 Prescaler behaviour: increments only while start=1 and load=0; holds its value while start=0; produces a step tick when it reaches PRESCALE-1, then returns to 0.
REQ-020 With PRESCALE=1, every cycle with start=1 and load=0 shall be a step tick.
REQ-021 On a tick the count shall move by one in direction ud, with decimal borrow/carry across digits, visible one edge after the tick.
REQ-022 Up tick at MAX_VALUE: wrap=1 gives 0; wrap=0 holds at MAX_VALUE.
REQ-023 Down tick at 0: wrap=1 gives MAX_VALUE; wrap=0 holds at 0.
REQ-024 tc shall be 1 for one cycle, coincident with the count update, for every tick taken at a boundary (wrapped or blocked); otherwise tc shall be 0.
REQ-025 Changing ud or wrap mid-count shall take effect on the next tick, with no lost or duplicate step.
REQ-026 HEX shall be a combinational decode of count.
REQ-027 Decode table: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.

Reset
REQ-028 Reset shall clear count, the prescaler, tc and err to 0, overriding load and start in the same cycle.
REQ-029 After reset, HEX digit 0 shall be 40h; the other digits shall follow REQ-031/032.
REQ-030 Reset asserted mid-count shall take effect on the next edge, with no residual tick after reset is released.

Configuration
REQ-031 With LEADING_ZERO_BLANK_EN defined, every zero digit more significant than the highest nonzero digit shall drive 7Fh (all segments off); digit 0 shall never be blanked.
REQ-032 With LEADING_ZERO_BLANK_EN undefined, every digit shall always be decoded per REQ-027.

Verification (DIGITS=2, MAX_VALUE=99, PRESCALE=1 unless stated)
REQ-033 Load 03h, then start=1, ud=0 for 3 cycles -> count 04h, 05h, 06h; tc stays 0.
REQ-034 Load 99h, wrap=1, ud=0, one tick -> count 00h, tc=1 for one cycle; with wrap=0 instead -> count stays 99h, tc pulses on each tick.
REQ-035 Count 00h, ud=1, wrap=1, one tick -> count 99h, tc=1; ud toggled mid-run -> no skipped or repeated values.
REQ-036 Load 1Ah -> count unchanged, err=1 for one cycle; then load 42h -> count 42h, HEX[13:7]=19h, HEX[6:0]=24h.
REQ-037 PRESCALE=4: start=1 -> one step per 4 cycles; start=0 for 2 cycles mid-period -> period resumes where it stopped; reset mid-period -> count 00h and a full 4-cycle period before the next step.
REQ-038 Count 07h -> HEX[13:7]=7Fh with LEADING_ZERO_BLANK_EN, 40h without; count 00h -> HEX[6:0]=40h in both builds.

Source files
------------

// File: rtl/seg_updown_counter.sv
//-----------------------------------------------------------------------------
// seg_updown_counter
//
// Purpose:
//   Multi-digit BCD up/down counter with prescaled step rate, parallel load
//   with validity checking, wrap/saturate boundary modes and a combinational
//   seven-segment decode of every digit.
//
// Parameters:
//   DIGITS     number of BCD digits / displays (1..6)
//   MAX_VALUE  upper count bound, decimal (1 .. 10^DIGITS-1)
//   PRESCALE   enabled clk cycles per count step (1 .. 65536)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       count enable (1 = count, 0 = hold)
//   ud          direction (0 = up, 1 = down)
//   wrap        boundary mode (1 = wrap, 0 = saturate)
//   load        single-cycle request to load startValue
//   startValue  BCD load value, digit 0 in bits [3:0]
//   count       registered BCD count
//   HEX         active-low segments, digit i in [7i+6:7i], {g,f,e,d,c,b,a}
//   tc          registered terminal-count pulse (boundary tick)
//   err         registered rejected-load pulse
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//                          significant nonzero digit are blanked (7Fh).
//-----------------------------------------------------------------------------
module seg_updown_counter #(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = 99,
  parameter int PRESCALE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ud,
  input  logic                  wrap,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   startValue,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  tc,
  output logic                  err
);

  // Convert the decimal bound to its BCD image at elaboration time so the
  // boundary and load-range checks can compare BCD vectors directly.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
    logic [4*DIGITS-1:0] result;
    int                  rem;
    result = '0;
    rem    = value;
    for (int i = 0; i < DIGITS; i++) begin
      result[4*i +: 4] = 4'(rem % 10);
      rem              = rem / 10;
    end
    return result;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  // Prescaler width: PRESCALE-1 must fit; PRESCALE = 1 still gets one bit
  // that simply stays at zero.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  //---------------------------------------------------------------------------
  // State
  //---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_reg, count_next;
  logic [PW-1:0]       pre_reg,   pre_next;
  logic                tc_reg,    tc_next;
  logic                err_reg,   err_next;

  //---------------------------------------------------------------------------
  // Per-digit BCD increment / decrement and load validation.
  // A digit steps only when every lower digit is at its rollover value
  // (9 going up, 0 going down), which gives decimal carry/borrow.
  //---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_dec;
  logic [DIGITS-1:0]   lower_nine;
  logic [DIGITS-1:0]   lower_zero;
  logic [DIGITS-1:0]   digit_ok;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d = count_reg[4*gi +: 4];

      if (gi == 0) begin : g_first
        assign lower_nine[gi] = 1'b1;
        assign lower_zero[gi] = 1'b1;
      end else begin : g_rest
        assign lower_nine[gi] = lower_nine[gi-1] & (count_reg[4*(gi-1) +: 4] == 4'd9);
        assign lower_zero[gi] = lower_zero[gi-1] & (count_reg[4*(gi-1) +: 4] == 4'd0);
      end

      assign count_inc[4*gi +: 4] = !lower_nine[gi] ? d :
                                    (d == 4'd9)     ? 4'd0 : d + 4'd1;
      assign count_dec[4*gi +: 4] = !lower_zero[gi] ? d :
                                    (d == 4'd0)     ? 4'd9 : d - 4'd1;

      assign digit_ok[gi] = (startValue[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  // With every digit a legal BCD value, BCD ordering equals binary ordering,
  // so a plain vector compare against MAX_BCD is a correct range check.
  logic load_ok;
  assign load_ok = (&digit_ok) && (startValue <= MAX_BCD);

  logic at_max;
  logic at_zero;
  assign at_max  = (count_reg == MAX_BCD);
  assign at_zero = (count_reg == '0);

  //---------------------------------------------------------------------------
  // Next-state logic: load has priority over the count step; reset is
  // applied in the register block and overrides everything.
  //---------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    pre_next   = pre_reg;
    tc_next    = 1'b0;
    err_next   = 1'b0;

    if (load) begin
      // An invalid load leaves both the count and the prescaler untouched.
      if (load_ok) begin
        count_next = startValue;
        pre_next   = '0;
      end else begin
        err_next = 1'b1;
      end
    end else if (start) begin
      if (pre_reg == PRE_LAST) begin
        pre_next = '0;
        if (!ud) begin
          if (at_max) begin
            tc_next    = 1'b1;
            count_next = wrap ? '0 : count_reg;
          end else begin
            count_next = count_inc;
          end
        end else begin
          if (at_zero) begin
            tc_next    = 1'b1;
            count_next = wrap ? MAX_BCD : count_reg;
          end else begin
            count_next = count_dec;
          end
        end
      end else begin
        pre_next = pre_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      pre_reg   <= '0;
      tc_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      pre_reg   <= pre_next;
      tc_reg    <= tc_next;
      err_reg   <= err_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign err   = err_reg;

  //---------------------------------------------------------------------------
  // Seven-segment decode (combinational from the registered count)
  //---------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[i] is set when digit i and every digit above it are zero.
  // Digit 0 is excluded from blanking so a zero count still shows "0".
  logic [DIGITS:0]   zero_from;
  logic [DIGITS-1:0] blank;

  assign zero_from[DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
      assign zero_from[gi] = zero_from[gi+1] & (count_reg[4*gi +: 4] == 4'd0);
      assign blank[gi]     = (gi != 0) && zero_from[gi];
      assign HEX[7*gi +: 7] = blank[gi] ? 7'h7F : seg7(count_reg[4*gi +: 4]);
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign HEX[7*gi +: 7] = seg7(count_reg[4*gi +: 4]);
    end
  endgenerate
`endif

endmodule
